// File: rtl/fetch_req_sched_pkg.sv
// Shared constants, state/priority encodings and helpers for the IF-stage fetch-request scheduler.
package fetch_req_sched_pkg;

    localparam logic [31:0] RESET_PC_DEF      = 32'hBFC0_0000;
    localparam int unsigned FETCH_BLOCK_BYTES = 16;
    localparam int unsigned INFL_W            = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_STALL = 2'd2
    } fetch_state_e;

    // Next-PC sources, listed from highest to lowest priority
    typedef enum logic [2:0] {
        SRC_CP0  = 3'd0,
        SRC_SBA  = 3'd1,
        SRC_BSC  = 3'd2,
        SRC_BTB  = 3'd3,
        SRC_SEQ  = 3'd4,
        SRC_HOLD = 3'd5
    } npc_src_e;

    function automatic logic [3:0] inst_enable(input logic [1:0] word_ofs);
        return 4'b1111 << word_ofs;
    endfunction

endpackage

// File: rtl/fetch_npc_sel.sv
// Next fetch-PC selection: fixed-priority redirect mux plus sequential fetch-block adder.
module fetch_npc_sel
    import fetch_req_sched_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic        i_exc,
    input  logic [31:0] i_exc_dest,
    input  logic        i_sba,
    input  logic [31:0] i_sba_dest,
    input  logic        i_bsc,
    input  logic [31:0] i_bsc_dest,
    input  logic        i_btb_take,
    input  logic [31:0] i_btb_dest,
    input  logic        i_handshake,
    output logic [31:0] o_npc_c,
    output logic        o_redirect_c,
    output logic        o_update_c
);

    npc_src_e    w_src;
    logic [31:0] w_seq;

    // Sequential target is the next aligned fetch block; wraps naturally at 2^32
    assign w_seq = (i_pc & ~32'(FETCH_BLOCK_BYTES - 1)) + 32'(FETCH_BLOCK_BYTES);

    always_comb begin
        w_src = SRC_HOLD;
        if (i_exc)                         w_src = SRC_CP0;
        else if (i_sba)                    w_src = SRC_SBA;
        else if (i_bsc)                    w_src = SRC_BSC;
        else if (i_handshake && i_btb_take) w_src = SRC_BTB;
        else if (i_handshake)              w_src = SRC_SEQ;
    end

    always_comb begin
        o_npc_c = i_pc;
        case (w_src)
            SRC_CP0: o_npc_c = i_exc_dest;
            SRC_SBA: o_npc_c = i_sba_dest;
            SRC_BSC: o_npc_c = i_bsc_dest;
            SRC_BTB: o_npc_c = i_btb_dest;
            SRC_SEQ: o_npc_c = w_seq;
            default: o_npc_c = i_pc;
        endcase
    end

    assign o_redirect_c = i_exc | i_sba | i_bsc;
    assign o_update_c   = (w_src != SRC_HOLD);

endmodule

// File: rtl/fetch_req_sched.sv
// IF-stage fetch-request scheduler: owns the fetch PC, the I-cache request handshake,
// in-flight limiting and stale-response discard tracking after redirects.
module fetch_req_sched
    import fetch_req_sched_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
    parameter int unsigned MAX_INFLIGHT = 2
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        CP0_excOccur_w_i,
    input  logic [31:0] CP0_excDest_i,
    input  logic        SBA_flush_w_i,
    input  logic [31:0] SBA_flushDest_i,
    input  logic        BSC_needCancel_w_i,
    input  logic [31:0] BSC_dest_i,
    input  logic        BTB_validTake_i,
    input  logic [31:0] BTB_validDest_i,
    input  logic        inst_index_ok_i,
    input  logic        inst_data_ok_i,
    input  logic        FCT_valid_i,
    input  logic        SCT_allowin_w_i,
    output logic        inst_req_o,
    output logic [31:0] PCR_VAddr_o,
    output logic [3:0]  PCR_instEnable_o,
    output logic        FRS_cancel_o,
    output logic        FRS_drop_o,
    output logic [1:0]  FRS_inflight_o
);

    fetch_state_e      r_state;
    logic [31:0]       r_pc;
    logic [3:0]        r_en;
    logic [INFL_W-1:0] r_inflight;
    logic [INFL_W-1:0] r_discard;

    logic              w_can_issue;
    logic              w_hs;
    logic              w_redirect;
    logic              w_update;
    logic [31:0]       w_npc;
    logic [INFL_W-1:0] w_infl_next;
    logic [INFL_W-1:0] w_disc_next;

    // A response arriving while at the limit does not free a slot until next cycle
    assign w_can_issue = (r_inflight < INFL_W'(MAX_INFLIGHT)) && (!FCT_valid_i || SCT_allowin_w_i);
    assign inst_req_o  = (r_state != ST_IDLE) && w_can_issue;
    assign w_hs        = inst_req_o && inst_index_ok_i;

    fetch_npc_sel u_npc_sel (
        .i_pc         (r_pc),
        .i_exc        (CP0_excOccur_w_i),
        .i_exc_dest   (CP0_excDest_i),
        .i_sba        (SBA_flush_w_i),
        .i_sba_dest   (SBA_flushDest_i),
        .i_bsc        (BSC_needCancel_w_i),
        .i_bsc_dest   (BSC_dest_i),
        .i_btb_take   (BTB_validTake_i),
        .i_btb_dest   (BTB_validDest_i),
        .i_handshake  (w_hs),
        .o_npc_c      (w_npc),
        .o_redirect_c (w_redirect),
        .o_update_c   (w_update)
    );

    // In-flight count saturates at zero on a spurious response
    always_comb begin
        w_infl_next = r_inflight;
        if (w_hs && !inst_data_ok_i)
            w_infl_next = r_inflight + INFL_W'(1);
        else if (!w_hs && inst_data_ok_i && (r_inflight != '0))
            w_infl_next = r_inflight - INFL_W'(1);
    end

    // On redirect every access still owed by the cache, including one accepted now, is stale
    always_comb begin
        w_disc_next = r_discard;
        if (w_redirect)
            w_disc_next = w_infl_next;
        else if (inst_data_ok_i && (r_discard != '0))
            w_disc_next = r_discard - INFL_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_en       <= inst_enable(RESET_PC[3:2]);
            r_inflight <= '0;
            r_discard  <= '0;
        end else begin
            if (w_update) begin
                r_pc <= w_npc;
                r_en <= inst_enable(w_npc[3:2]);
            end
            r_inflight <= w_infl_next;
            r_discard  <= w_disc_next;
            if (w_redirect) begin
                r_state <= ST_REQ;
            end else begin
                case (r_state)
                    ST_IDLE:  r_state <= ST_REQ;
                    ST_REQ:   if (!w_can_issue) r_state <= ST_STALL;
                    ST_STALL: if (w_can_issue)  r_state <= ST_REQ;
                    default:  r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign PCR_VAddr_o      = r_pc;
    assign PCR_instEnable_o = r_en;
    assign FRS_inflight_o   = r_inflight;
    assign FRS_cancel_o     = w_hs && w_redirect;
    assign FRS_drop_o       = inst_data_ok_i && (r_discard != '0);

endmodule

// File: tb/tb_fetch_req_sched.sv
// Directed table-driven bench for fetch_req_sched with hand-computed expectations.
module tb_fetch_req_sched;

    logic        clk;
    logic        rst;
    logic        exc, sba, bsc, btb;
    logic [31:0] exc_d, sba_d, bsc_d, btb_d;
    logic        idx_ok, dok, fct, sct;
    logic        inst_req;
    logic [31:0] vaddr;
    logic [3:0]  inst_en;
    logic        cancel, drop;
    logic [1:0]  inflight;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        exc;  logic [31:0] exc_d;
        logic        sba;  logic [31:0] sba_d;
        logic        bsc;  logic [31:0] bsc_d;
        logic        btb;  logic [31:0] btb_d;
        logic        idx;  logic        dok;
        logic        fct;  logic        sct;
        logic        req;  logic        cancel;
        logic        drop; logic [1:0]  infl;
        logic [31:0] pc;   logic [3:0]  en;
    } vec_t;

    vec_t tbl[$];

    fetch_req_sched #(.RESET_PC(32'hBFC0_0000), .MAX_INFLIGHT(2)) dut (
        .clk                (clk),
        .rst                (rst),
        .CP0_excOccur_w_i   (exc),
        .CP0_excDest_i      (exc_d),
        .SBA_flush_w_i      (sba),
        .SBA_flushDest_i    (sba_d),
        .BSC_needCancel_w_i (bsc),
        .BSC_dest_i         (bsc_d),
        .BTB_validTake_i    (btb),
        .BTB_validDest_i    (btb_d),
        .inst_index_ok_i    (idx_ok),
        .inst_data_ok_i     (dok),
        .FCT_valid_i        (fct),
        .SCT_allowin_w_i    (sct),
        .inst_req_o         (inst_req),
        .PCR_VAddr_o        (vaddr),
        .PCR_instEnable_o   (inst_en),
        .FRS_cancel_o       (cancel),
        .FRS_drop_o         (drop),
        .FRS_inflight_o     (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A response with nothing outstanding is illegal stimulus
    always @(negedge clk) begin
        if (rst && dok && (inflight == 2'd0)) begin
            errors++;
            $display("FAIL illegal_data_ok: got inflight %0d required nonzero", inflight);
        end
    end

    function automatic vec_t v(
        input logic e, input logic [31:0] ed, input logic s, input logic [31:0] sd,
        input logic b, input logic [31:0] bd, input logic t, input logic [31:0] td,
        input logic ix, input logic dk, input logic fv, input logic sa,
        input logic rq, input logic cn, input logic dr, input logic [1:0] inf,
        input logic [31:0] pc, input logic [3:0] en);
        vec_t r;
        r.exc = e;  r.exc_d = ed; r.sba = s; r.sba_d = sd;
        r.bsc = b;  r.bsc_d = bd; r.btb = t; r.btb_d = td;
        r.idx = ix; r.dok = dk;   r.fct = fv; r.sct = sa;
        r.req = rq; r.cancel = cn; r.drop = dr; r.infl = inf;
        r.pc = pc;  r.en = en;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        exc = 0; sba = 0; bsc = 0; btb = 0;
        exc_d = '0; sba_d = '0; bsc_d = '0; btb_d = '0;
        idx_ok = 0; dok = 0; fct = 0; sct = 0;
    endtask

    initial begin
        //            exc  exc_d         sba  sba_d         bsc  bsc_d         btb  btb_d         idx dok fct sct | req cn dr inf pc            en
        tbl.push_back(v(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 0, 0,  0, 0, 0, 0, 32'hBFC0_0000, 4'hF));
        tbl.push_back(v(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 0, 0,  1, 0, 0, 0, 32'hBFC0_0000, 4'hF));
        tbl.push_back(v(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1, 0, 0,  1, 0, 0, 1, 32'hBFC0_0010, 4'hF));
        tbl.push_back(v(0, 32'h0,        1, 32'h8000_0184, 0, 32'h0,       0, 32'h0,        0, 0, 0, 0,  1, 0, 0, 0, 32'hBFC0_0010, 4'hF));
        tbl.push_back(v(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 0, 0,  1, 0, 0, 0, 32'h8000_0184, 4'hE));
        tbl.push_back(v(0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h0040_0008, 1, 0, 0, 0, 1, 0, 0, 1, 32'h8000_0190, 4'hF));
        tbl.push_back(v(0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h1234_5670, 1, 0, 0, 0, 0, 0, 0, 2, 32'h0040_0008, 4'hC));
        tbl.push_back(v(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 0, 0,  0, 0, 0, 2, 32'h0040_0008, 4'hC));
        tbl.push_back(v(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 1, 0, 0,  0, 0, 0, 2, 32'h0040_0008, 4'hC));
        tbl.push_back(v(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  1, 0, 0, 1, 32'h0040_0008, 4'hC));
        tbl.push_back(v(1, 32'hBFC0_0380, 0, 32'h0,       1, 32'h8000_1000, 0, 32'h0,       1, 0, 0, 0,  1, 1, 0, 1, 32'h0040_0008, 4'hC));
        tbl.push_back(v(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1, 0, 0,  0, 0, 1, 2, 32'hBFC0_0380, 4'hF));
        tbl.push_back(v(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1, 0, 0,  1, 0, 1, 1, 32'hBFC0_0380, 4'hF));
        tbl.push_back(v(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 1, 0,  0, 0, 0, 0, 32'hBFC0_0380, 4'hF));
        tbl.push_back(v(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 1, 1,  1, 0, 0, 0, 32'hBFC0_0380, 4'hF));
        tbl.push_back(v(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 0, 0,  1, 0, 0, 1, 32'hBFC0_0390, 4'hF));
        tbl.push_back(v(0, 32'h0,        0, 32'h0,        1, 32'h0000_1004, 0, 32'h0,       0, 0, 0, 0,  0, 0, 0, 2, 32'hBFC0_03A0, 4'hF));
        tbl.push_back(v(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1, 0, 0,  0, 0, 1, 2, 32'h0000_1004, 4'hE));
        tbl.push_back(v(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1, 0, 0,  1, 0, 1, 1, 32'h0000_1004, 4'hE));
        tbl.push_back(v(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 0, 0,  1, 0, 0, 0, 32'h0000_1004, 4'hE));
        tbl.push_back(v(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1, 0, 0,  1, 0, 0, 1, 32'h0000_1010, 4'hF));
        tbl.push_back(v(0, 32'h0,        1, 32'hFFFF_FFF4, 0, 32'h0,       0, 32'h0,        0, 0, 0, 0,  1, 0, 0, 0, 32'h0000_1010, 4'hF));
        tbl.push_back(v(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 0, 0,  1, 0, 0, 0, 32'hFFFF_FFF4, 4'hE));
        tbl.push_back(v(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1, 0, 0,  1, 0, 0, 1, 32'h0000_0000, 4'hF));
        tbl.push_back(v(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 0, 0,  1, 0, 0, 0, 32'h0000_0000, 4'hF));
        tbl.push_back(v(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 1, 0, 0,  1, 0, 0, 1, 32'h0000_0010, 4'hF));
        tbl.push_back(v(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  1, 0, 0, 1, 32'h0000_0020, 4'hF));
        tbl.push_back(v(0, 32'h0,        1, 32'h1111_1110, 1, 32'h2222_2220, 1, 32'h3333_3330, 1, 0, 0, 0, 1, 1, 0, 1, 32'h0000_0020, 4'hF));
        tbl.push_back(v(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1, 0, 0,  0, 0, 1, 2, 32'h1111_1110, 4'hF));
        tbl.push_back(v(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1, 0, 0,  1, 0, 1, 1, 32'h1111_1110, 4'hF));
        tbl.push_back(v(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  1, 0, 0, 0, 32'h1111_1110, 4'hF));

        clear_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset req",      32'(inst_req), 32'd0);
        chk("reset pc",       vaddr,         32'hBFC0_0000);
        chk("reset en",       32'(inst_en),  32'hF);
        chk("reset cancel",   32'(cancel),   32'd0);
        chk("reset drop",     32'(drop),     32'd0);
        chk("reset inflight", 32'(inflight), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            exc = tbl[i].exc; exc_d = tbl[i].exc_d;
            sba = tbl[i].sba; sba_d = tbl[i].sba_d;
            bsc = tbl[i].bsc; bsc_d = tbl[i].bsc_d;
            btb = tbl[i].btb; btb_d = tbl[i].btb_d;
            idx_ok = tbl[i].idx; dok = tbl[i].dok;
            fct = tbl[i].fct;    sct = tbl[i].sct;
            @(negedge clk);
            chk($sformatf("v%0d req", i),      32'(inst_req), 32'(tbl[i].req));
            chk($sformatf("v%0d cancel", i),   32'(cancel),   32'(tbl[i].cancel));
            chk($sformatf("v%0d drop", i),     32'(drop),     32'(tbl[i].drop));
            chk($sformatf("v%0d inflight", i), 32'(inflight), 32'(tbl[i].infl));
            chk($sformatf("v%0d pc", i),       vaddr,         tbl[i].pc);
            chk($sformatf("v%0d en", i),       32'(inst_en),  32'(tbl[i].en));
            @(posedge clk);
            #1;
        end

        // Reset asserted mid-operation with one access outstanding
        clear_inputs();
        idx_ok = 1'b1;
        @(negedge clk);
        chk("midrst pre req", 32'(inst_req), 32'd1);
        @(posedge clk);
        #1;
        idx_ok = 1'b0;
        chk("midrst pre inflight", 32'(inflight), 32'd1);
        chk("midrst pre pc",       vaddr,         32'h1111_1120);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst pc",       vaddr,         32'hBFC0_0000);
        chk("midrst en",       32'(inst_en),  32'hF);
        chk("midrst inflight", 32'(inflight), 32'd0);
        chk("midrst req",      32'(inst_req), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst idle req", 32'(inst_req), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst first req", 32'(inst_req), 32'd1);
        chk("midrst first pc",  vaddr,          32'hBFC0_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_req_sched.md
# fetch_req_sched

Fetch-request scheduler sitting in front of the instruction-cache pipeline in the IF stage. It owns the fetch PC register and the `inst_req` handshake toward the I-cache, chooses the next fetch address from redirect sources by fixed priority, and limits the number of in-flight cache accesses. It also tracks which outstanding responses must be discarded after a redirect, and produces the 4-slot instruction enable that accompanies each request into the first cache-trace stage.

## Interface
- `RESET_PC`, 32'hBFC0_0000, fetch address after reset
- `MAX_INFLIGHT`, 2, max accepted-but-unreturned requests (1..3)
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-low reset
- `CP0_excOccur_w_i` / `CP0_excDest_i`  in  1 / 32  exception redirect
- `SBA_flush_w_i` / `SBA_flushDest_i`  in  1 / 32  branch-recovery redirect
- `BSC_needCancel_w_i` / `BSC_dest_i`  in  1 / 32  predictor-disagreement redirect
- `BTB_validTake_i` / `BTB_validDest_i`  in  1 / 32  BTB taken prediction for the current fetch
- `inst_index_ok_i`  in  1  cache accepted request this cycle
- `inst_data_ok_i`  in  1  cache returned one response this cycle
- `FCT_valid_i`  in  1  first trace stage holds data
- `SCT_allowin_w_i`  in  1  second trace stage can accept
- `inst_req_o`  out  1  fetch request
- `PCR_VAddr_o`  out  32  fetch virtual address
- `PCR_instEnable_o`  out  4  valid slots of the 16-byte fetch block
- `FRS_cancel_o`  out  1  request accepted this cycle is already stale
- `FRS_drop_o`  out  1  current `inst_data_ok_i` response must be discarded
- `FRS_inflight_o`  out  2  in-flight count

## Operation
- States: IDLE, REQ, STALL.
  - IDLE: one cycle after reset, then REQ.
  - REQ: `inst_req_o`=1 when `inflight < MAX_INFLIGHT` and (`!FCT_valid_i || SCT_allowin_w_i`).
  - REQ → STALL when either condition fails. STALL → REQ when both conditions hold again.
- Any redirect forces REQ on the next cycle.
- Next-PC priority: CP0 exc > SBA flush > BSC cancel > BTB taken (only applied on a handshake) > sequential.
  - Sequential address = `{PC[31:4],4'b0} + 16`, wrapping modulo 2^32.
- PC update rules:
  - PC changes only on a handshake (`inst_req_o && inst_index_ok_i`) or on a redirect.
  - A redirect is taken regardless of handshake.
- `PCR_instEnable_o` = `4'b1111 << PC[3:2]`. PC[1:0] is ignored.
- In-flight count: +1 on handshake, −1 on `inst_data_ok_i`; both in the same cycle leaves it unchanged.
- Discard counter:
  - On redirect it loads `inflight + handshake − data_ok`.
  - Otherwise it decrements on `inst_data_ok_i` when nonzero.
  - `FRS_drop_o` = `inst_data_ok_i && discard != 0`.
- `FRS_cancel_o` = handshake && redirect in the same cycle. The cancelled access is counted in discard.
- `inst_data_ok_i` with inflight==0 is illegal: the bench asserts on it, and the RTL saturates the count at 0.

## Timing
- Reset (async assert):
  - `inst_req_o`=0, `PCR_VAddr_o`=`RESET_PC`, `PCR_instEnable_o`=4'b1111.
  - `FRS_cancel_o`=0, `FRS_drop_o`=0, `FRS_inflight_o`=0, discard=0, state IDLE.
- First `inst_req_o` occurs 2nd rising edge after `rst` deassertion.
- Redirect latency: target on `PCR_VAddr_o` the cycle after the redirect pulse. The request is issuable that same cycle.
- `inst_req_o`, `FRS_cancel_o` and `FRS_drop_o` are combinational from registered state plus same-cycle inputs. `PCR_*` are registered.
- Simultaneous redirects: highest priority wins. Lower-priority targets are lost.
- Inflight==MAX with `inst_data_ok_i` in the same cycle: no request that cycle (conservative). The request is issued next cycle.
- Reset mid-operation clears all counters. Responses still in flight from the cache are not tracked; the cache is reset by the same `rst`.

## Structure
- Shared defines header: `RESET_PC` default, fetch-block size (16 bytes), state encodings, redirect-priority constants.
- One sub-module, `fetch_npc_sel`: combinational next-PC priority mux plus sequential-address adder.
- Counters and FSM stay in the top module.

## Test plan
- Reset release:
  - `rst` 0→1 → `PCR_VAddr_o`=BFC0_0000, enable 1111, `inst_req_o` high on 2nd edge.
  - Handshake → next PC BFC0_0010.
- Unaligned redirect:
  - SBA flush to 8000_0184 → next cycle PC 8000_0184, enable 1110.
  - After handshake → PC 8000_0190.
- Priority:
  - CP0 to BFC0_0380 and BSC to 8000_1000 in the same cycle as a handshake → PC BFC0_0380, `FRS_cancel_o`=1, discard=inflight+1.
- Backpressure:
  - MAX_INFLIGHT=2 with no `data_ok` → exactly two handshakes then STALL.
  - `FCT_valid_i`=1 with `SCT_allowin_w_i`=0 → `inst_req_o`=0.
- Drop:
  - Two in flight, redirect with no handshake → discard=2.
  - Next two `data_ok` → `FRS_drop_o`=1 both times, third response not dropped.
- Wrap:
  - PC FFFF_FFF4 handshake, no redirect → next PC 0000_0000, enable 1111.
